// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES S-box table, FSM state type and width constants shared by the S-box stage
package des_pkg;

  localparam int W_IN    = 48;
  localparam int W_OUT   = 32;
  localparam int W_CHUNK = 6;
  localparam int W_NIB   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Entry {box, row} holds one S-box row; column 0 is the most significant nibble
  localparam logic [63:0] SBOX_ROW [0:31] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A628E5CBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1D6B, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

endpackage

// File: rtl/des_sbox_lut.sv
// rtl/des_sbox_lut.sv - combinational lookup of one DES S-box (box index 0..7 selects S1..S8)
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0]         i_box,
  input  logic [W_CHUNK-1:0] i_chunk,
  output logic [W_NIB-1:0]   o_nib
);

  logic [1:0]  w_row;
  logic [3:0]  w_col;
  logic [63:0] w_line;

  // Outer bits pick the row, inner four bits the column
  assign w_row  = {i_chunk[5], i_chunk[0]};
  assign w_col  = i_chunk[4:1];
  assign w_line = SBOX_ROW[{i_box, w_row}];
  assign o_nib  = w_line[{~w_col, 2'b00} +: 4];

endmodule

// File: rtl/des_sbox_serial.sv
// rtl/des_sbox_serial.sv - serial DES S1..S8 substitution with valid/ready on both sides
// Define DES_SBOX_SERIAL_UNROLL2_EN to evaluate two S-boxes per BUSY cycle.
module des_sbox_serial
  import des_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:W_IN]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:W_OUT]  out_data
);

`ifdef DES_SBOX_SERIAL_UNROLL2_EN
  localparam int         STEP     = 2 * W_CHUNK;
  localparam logic [2:0] IDX_INC  = 3'd2;
  localparam logic [2:0] IDX_LAST = 3'd6;
`else
  localparam int         STEP     = W_CHUNK;
  localparam logic [2:0] IDX_INC  = 3'd1;
  localparam logic [2:0] IDX_LAST = 3'd7;
`endif

  state_t            r_state;
  logic [2:0]        r_idx;
  logic [1:W_IN]     r_sh;
  logic [1:W_OUT]    r_out;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [W_NIB-1:0]  w_nib0;
  logic [1:W_OUT]    w_out_next;

  des_sbox_lut u_lut0 (
    .i_box   (r_idx),
    .i_chunk (r_sh[1:6]),
    .o_nib   (w_nib0)
  );

`ifdef DES_SBOX_SERIAL_UNROLL2_EN
  logic [W_NIB-1:0]  w_nib1;

  des_sbox_lut u_lut1 (
    .i_box   (r_idx + 3'd1),
    .i_chunk (r_sh[7:12]),
    .o_nib   (w_nib1)
  );

  assign w_out_next = {r_out[9:W_OUT], w_nib0, w_nib1};
`else
  assign w_out_next = {r_out[5:W_OUT], w_nib0};
`endif

  // Handshake outputs are registered and follow the state only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= 3'd0;
      r_sh        <= '0;
      r_out       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sh       <= in_data;
            r_idx      <= 3'd0;
            r_state    <= BUSY;
            r_in_ready <= 1'b0;
          end
        end
        BUSY: begin
          r_sh  <= {r_sh[STEP+1:W_IN], {STEP{1'b0}}};
          r_out <= w_out_next;
          if (r_idx == IDX_LAST) begin
            r_idx       <= 3'd0;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_INC;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out;

endmodule
